fft_adc_loader: RTL and testbench

//  Frame loader directly upstream of fft_top. Accepts a stream of signed ADC samples and writes

---
 rtl/fft_adc_loader.sv | 211 +++++++++++++++++++++
 tb/tb_fft_adc_loader.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_adc_loader.sv
// -----------------------------------------------------------------------------
// fft_adc_loader
//   Frame loader placed directly in front of fft_top. Signed ADC samples are
//   written, in arrival order, into fft_top's four input RAM banks. A frame
//   holds 4*2**ADDR_W samples. After the last write of a frame the loader waits
//   START_GAP idle cycles, pulses oSTART for one cycle, and then discards
//   samples until fft_top's oRDY rises again.
//
// Ports
//   iCLK                 system clock, rising edge
//   iRESET               asynchronous active-low reset
//   iENABLE              1 = capture frames back to back; 0 = finish frame, idle
//   iDATA / iVALID       sample and its strobe
//   iFFT_RDY             fft_top oRDY level
//   oDATA                sample to fft_top iDATA
//   oADDR_WR_0..3        per-bank write addresses (hold value when not written)
//   oWE_0..3             per-bank write enables, one-hot or all zero
//   oSTART               single-cycle start pulse to fft_top
//   oBUSY                high whenever the loader is not idle
//   oDROP                one-cycle pulse per discarded sample
//   oDROP_CNT            (FFT_LOADER_DROP_CNT_EN only) saturating count of
//                        oDROP pulses, cleared on every oSTART
//
// Build option
//   FFT_LOADER_DROP_CNT_EN : adds the oDROP_CNT port and its counter.
//
// States
//   S_IDLE  | not capturing; iVALID ignored, no drops
//   S_FILL  | writing samples n = 0 .. frame-1 into the banks
//   S_GAP   | START_GAP idle cycles after the last write; samples dropped
//   S_START | issue the oSTART pulse; samples dropped
//   S_WAIT  | wait for a fresh rising edge of iFFT_RDY; samples dropped
// -----------------------------------------------------------------------------
module fft_adc_loader #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 9,
    parameter int START_GAP = 2     // legal range 1..15
) (
    input  logic              iCLK,
    input  logic              iRESET,
    input  logic              iENABLE,
    input  logic [DATA_W-1:0] iDATA,
    input  logic              iVALID,
    input  logic              iFFT_RDY,
    output logic [DATA_W-1:0] oDATA,
    output logic [ADDR_W-1:0] oADDR_WR_0,
    output logic [ADDR_W-1:0] oADDR_WR_1,
    output logic [ADDR_W-1:0] oADDR_WR_2,
    output logic [ADDR_W-1:0] oADDR_WR_3,
    output logic              oWE_0,
    output logic              oWE_1,
    output logic              oWE_2,
    output logic              oWE_3,
    output logic              oSTART,
    output logic              oBUSY,
    output logic              oDROP
`ifdef FFT_LOADER_DROP_CNT_EN
    ,
    output logic [15:0]       oDROP_CNT
`endif
);

    localparam int              N_W      = ADDR_W + 2;
    localparam logic [N_W-1:0]  N_LAST   = '1;
    localparam logic [3:0]      GAP_LOAD = 4'(START_GAP - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_GAP,
        S_START,
        S_WAIT
    } state_t;

    state_t                     state_q, state_d;
    logic [N_W-1:0]             n_q, n_d;
    logic [3:0]                 gap_q, gap_d;
    logic [DATA_W-1:0]          data_q, data_d;
    logic [3:0][ADDR_W-1:0]     addr_q, addr_d;
    logic [3:0]                 we_q, we_d;
    logic                       start_q, start_d;
    logic                       busy_q, busy_d;
    logic                       drop_q, drop_d;
    logic                       rdy_q, rdy_d;
    logic [1:0]                 bank;
    logic                       rdy_rise;

    always_comb begin
        state_d  = state_q;
        n_d      = n_q;
        gap_d    = gap_q;
        data_d   = data_q;
        addr_d   = addr_q;
        we_d     = '0;
        start_d  = 1'b0;
        drop_d   = 1'b0;
        rdy_d    = iFFT_RDY;
        bank     = n_q[N_W-1:ADDR_W];
        // rdy_q tracks the level every cycle, so a level that was already
        // high before entering S_WAIT never looks like a rising edge.
        rdy_rise = iFFT_RDY & ~rdy_q;

        case (state_q)
            S_IDLE: begin
                if (iENABLE) begin
                    state_d = S_FILL;
                end
            end
            S_FILL: begin
                if (iVALID) begin
                    data_d       = iDATA;
                    addr_d[bank] = n_q[ADDR_W-1:0];
                    we_d[bank]   = 1'b1;
                    if (n_q == N_LAST) begin
                        n_d     = '0;
                        gap_d   = GAP_LOAD;
                        state_d = S_GAP;
                    end else begin
                        n_d = n_q + 1'b1;
                    end
                end
            end
            S_GAP: begin
                drop_d = iVALID;
                if (gap_q == 4'd0) begin
                    state_d = S_START;
                end else begin
                    gap_d = gap_q - 4'd1;
                end
            end
            S_START: begin
                drop_d  = iVALID;
                start_d = 1'b1;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                drop_d = iVALID;
                if (rdy_rise) begin
                    state_d = iENABLE ? S_FILL : S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

`ifdef FFT_LOADER_DROP_CNT_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;

    // A drop coinciding with the start pulse is the first one of the new count.
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (start_d) begin
            drop_cnt_d = {15'd0, drop_d};
        end else if (drop_d && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    assign oDROP_CNT = drop_cnt_q;
`endif

    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            state_q    <= S_IDLE;
            n_q        <= '0;
            gap_q      <= '0;
            data_q     <= '0;
            addr_q     <= '0;
            we_q       <= '0;
            start_q    <= 1'b0;
            busy_q     <= 1'b0;
            drop_q     <= 1'b0;
            rdy_q      <= 1'b0;
`ifdef FFT_LOADER_DROP_CNT_EN
            drop_cnt_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            gap_q      <= gap_d;
            data_q     <= data_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            start_q    <= start_d;
            busy_q     <= busy_d;
            drop_q     <= drop_d;
            rdy_q      <= rdy_d;
`ifdef FFT_LOADER_DROP_CNT_EN
            drop_cnt_q <= drop_cnt_d;
`endif
        end
    end

    assign oDATA      = data_q;
    assign oADDR_WR_0 = addr_q[0];
    assign oADDR_WR_1 = addr_q[1];
    assign oADDR_WR_2 = addr_q[2];
    assign oADDR_WR_3 = addr_q[3];
    assign oWE_0      = we_q[0];
    assign oWE_1      = we_q[1];
    assign oWE_2      = we_q[2];
    assign oWE_3      = we_q[3];
    assign oSTART     = start_q;
    assign oBUSY      = busy_q;
    assign oDROP      = drop_q;

endmodule

// File: tb/tb_fft_adc_loader.sv
// -----------------------------------------------------------------------------
// tb_fft_adc_loader
//   Directed scenario sequence with randomized data/strobes for fft_adc_loader.
//   Expected writes are derived from the frame index (bank = n/512,
//   addr = n%512, output one cycle after the sample is presented) and checked
//   by a negedge monitor; scenario-level expectations are checked inline.
// -----------------------------------------------------------------------------
module tb_fft_adc_loader;

    localparam int DATA_W    = 16;
    localparam int ADDR_W    = 9;
    localparam int START_GAP = 2;
    localparam int BANK_N    = 512;
    localparam int FRAME_N   = 2048;

    logic              iCLK = 1'b0;
    logic              iRESET;
    logic              iENABLE;
    logic [DATA_W-1:0] iDATA;
    logic              iVALID;
    logic              iFFT_RDY;
    logic [DATA_W-1:0] oDATA;
    logic [ADDR_W-1:0] oADDR_WR_0, oADDR_WR_1, oADDR_WR_2, oADDR_WR_3;
    logic              oWE_0, oWE_1, oWE_2, oWE_3;
    logic              oSTART, oBUSY, oDROP;
`ifdef FFT_LOADER_DROP_CNT_EN
    logic [15:0]       oDROP_CNT;
`endif

    fft_adc_loader #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .START_GAP (START_GAP)
    ) dut (
        .iCLK       (iCLK),
        .iRESET     (iRESET),
        .iENABLE    (iENABLE),
        .iDATA      (iDATA),
        .iVALID     (iVALID),
        .iFFT_RDY   (iFFT_RDY),
        .oDATA      (oDATA),
        .oADDR_WR_0 (oADDR_WR_0),
        .oADDR_WR_1 (oADDR_WR_1),
        .oADDR_WR_2 (oADDR_WR_2),
        .oADDR_WR_3 (oADDR_WR_3),
        .oWE_0      (oWE_0),
        .oWE_1      (oWE_1),
        .oWE_2      (oWE_2),
        .oWE_3      (oWE_3),
        .oSTART     (oSTART),
        .oBUSY      (oBUSY),
        .oDROP      (oDROP)
`ifdef FFT_LOADER_DROP_CNT_EN
        ,
        .oDROP_CNT  (oDROP_CNT)
`endif
    );

    always #5 iCLK = ~iCLK;

    int cyc = 0;
    always @(posedge iCLK) cyc <= cyc + 1;

    typedef struct {
        int          bank;
        int          addr;
        logic [15:0] data;
        int          at;
    } wr_t;

    wr_t          exp_q[$];
    wr_t          mon_e;
    int           checks = 0;
    int           errors = 0;
    int           mdl_n;
    logic [15:0]  mdl_data;
    logic [8:0]   mdl_addr [4];
    logic [15:0]  ramp_base;
    int           writes = 0;
    int           starts = 0;
    int           drops  = 0;
    int           last_we_cyc = 0;
    logic         prev_start = 1'b0;
    logic [3:0]   mon_we;
    int           mon_wb;
    logic [8:0]   mon_wa;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge iCLK);
        #1;
    endtask

    task automatic model_reset();
        mdl_n    = 0;
        mdl_data = '0;
        for (int b = 0; b < 4; b++) mdl_addr[b] = '0;
        exp_q.delete();
    endtask

    // Monitor: every write must match the next expected sample, one cycle
    // after it was presented; outputs must hold between writes.
    always @(negedge iCLK) begin
        mon_we = {oWE_3, oWE_2, oWE_1, oWE_0};
        check("we_onehot", 32'($countones(mon_we) <= 1), 1);
        if (mon_we != 4'b0000) begin
            mon_wb = mon_we[1] ? 1 : mon_we[2] ? 2 : mon_we[3] ? 3 : 0;
            case (mon_wb)
                1:       mon_wa = oADDR_WR_1;
                2:       mon_wa = oADDR_WR_2;
                3:       mon_wa = oADDR_WR_3;
                default: mon_wa = oADDR_WR_0;
            endcase
            writes++;
            last_we_cyc = cyc;
            check("we_expected", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                check("wr_bank", mon_wb, mon_e.bank);
                check("wr_addr", 32'(mon_wa), mon_e.addr);
                check("wr_data", 32'(oDATA), 32'(mon_e.data));
                check("wr_latency", cyc, mon_e.at);
                mdl_data               = mon_e.data;
                mdl_addr[mon_e.bank]   = 9'(mon_e.addr);
            end
        end
        check("hold_data",  32'(oDATA),      32'(mdl_data));
        check("hold_addr0", 32'(oADDR_WR_0), 32'(mdl_addr[0]));
        check("hold_addr1", 32'(oADDR_WR_1), 32'(mdl_addr[1]));
        check("hold_addr2", 32'(oADDR_WR_2), 32'(mdl_addr[2]));
        check("hold_addr3", 32'(oADDR_WR_3), 32'(mdl_addr[3]));
        if (oSTART) begin
            starts++;
            check("start_after_last_we", cyc - last_we_cyc, START_GAP + 1);
            check("start_single", 32'(prev_start), 0);
`ifdef FFT_LOADER_DROP_CNT_EN
            check("drop_cnt_clear", 32'(oDROP_CNT), 0);
`endif
        end
        prev_start = oSTART;
        if (oDROP) drops++;
    end

    // Present samples until `count` have been accepted. mode 0: back-to-back
    // 16'd100; mode 1: one strobe every three cycles, ramp data; mode 2: random.
    task automatic fill(input int count, input int mode, input int en_drop_at);
        int          sent;
        int          ph;
        logic        v;
        logic [15:0] d;
        wr_t         e;
        sent = 0;
        ph   = 0;
        while (sent < count) begin
            if (en_drop_at >= 0 && mdl_n == en_drop_at) iENABLE = 1'b0;
            case (mode)
                0:       begin v = 1'b1;                   d = 16'd100; end
                1:       begin v = ((ph % 3) == 0);        d = 16'(ramp_base + 16'(mdl_n)); end
                default: begin v = 1'($urandom_range(0, 1)); d = 16'($urandom); end
            endcase
            iVALID = v;
            iDATA  = d;
            if (v) begin
                e.bank = mdl_n / BANK_N;
                e.addr = mdl_n % BANK_N;
                e.data = d;
                e.at   = cyc + 1;
                exp_q.push_back(e);
                mdl_n = (mdl_n + 1) % FRAME_N;
                sent++;
            end
            ph++;
            tick();
        end
        iVALID = 1'b0;
    endtask

    task automatic wait_start(input string tag);
        int s0;
        int n;
        s0 = starts;
        n  = 0;
        while (starts == s0 && n < 40) begin
            tick();
            n++;
        end
        check(tag, starts - s0, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    int w0, d0, s0, sent;

    initial begin
        iRESET   = 1'b0;
        iENABLE  = 1'b0;
        iVALID   = 1'b0;
        iDATA    = '0;
        iFFT_RDY = 1'b0;
        model_reset();
        repeat (2) tick();

        check("rst_we",    32'({oWE_3, oWE_2, oWE_1, oWE_0}), 0);
        check("rst_start", 32'(oSTART), 0);
        check("rst_busy",  32'(oBUSY), 0);
        check("rst_drop",  32'(oDROP), 0);
        iRESET = 1'b1;
        tick();
        check("idle_busy_init", 32'(oBUSY), 0);

        // Reset in the middle of a frame, right as sample 699 is on the bus.
        iENABLE = 1'b1;
        tick();
        fill(700, 2, -1);
        #1 iRESET = 1'b0;
        #1;
        check("rst_mid_we",    32'({oWE_3, oWE_2, oWE_1, oWE_0}), 0);
        check("rst_mid_data",  32'(oDATA), 0);
        check("rst_mid_addr1", 32'(oADDR_WR_1), 0);
        check("rst_mid_busy",  32'(oBUSY), 0);
        model_reset();
        tick();
        tick();
        iRESET = 1'b1;
        tick();

        // Full back-to-back frame; iFFT_RDY already high before the start pulse.
        iFFT_RDY = 1'b1;
        check("fill_busy", 32'(oBUSY), 1);
        w0 = writes;
        fill(FRAME_N, 0, -1);
        check("frame_writes", writes - w0, FRAME_N);
        wait_start("start_frame1");

        // Leftover high iFFT_RDY must not release the wait; samples dropped.
        d0   = drops;
        w0   = writes;
        sent = 0;
        while (sent < 40) begin
            iVALID = 1'($urandom_range(0, 1));
            iDATA  = 16'($urandom);
            if (iVALID) sent++;
            tick();
        end
        iVALID = 1'b0;
        tick();
        check("wait_drops", drops - d0, 40);
        check("wait_no_we", writes - w0, 0);
        check("wait_busy",  32'(oBUSY), 1);
`ifdef FFT_LOADER_DROP_CNT_EN
        check("drop_cnt_40", 32'(oDROP_CNT), 40);
`endif

        // Rising edge releases to FILL; the strobe in that same cycle is dropped.
        iFFT_RDY = 1'b0;
        tick();
        iFFT_RDY = 1'b1;
        iVALID   = 1'b1;
        iDATA    = 16'($urandom);
        d0       = drops;
        tick();
        iVALID = 1'b0;
        check("edge_cycle_drop", drops - d0, 1);

        // Sparse ramp frame, enable dropped at n=1000: frame still completes.
        ramp_base = 16'($urandom);
        w0        = writes;
        fill(FRAME_N, 1, 1000);
        check("frame2_writes", writes - w0, FRAME_N);
        wait_start("start_frame2");
        check("frame2_wait_busy", 32'(oBUSY), 1);
        iFFT_RDY = 1'b0;
        tick();
        iFFT_RDY = 1'b1;
        tick();
        tick();
        check("idle_after_disable", 32'(oBUSY), 0);
        w0 = writes;
        d0 = drops;
        repeat (10) begin
            iVALID = 1'b1;
            iDATA  = 16'($urandom);
            tick();
        end
        iVALID = 1'b0;
        tick();
        check("idle_no_we",   writes - w0, 0);
        check("idle_no_drop", drops - d0, 0);

        // Two consecutive frames in continuous mode.
        s0      = starts;
        iENABLE = 1'b1;
        tick();
        fill(FRAME_N, 2, -1);
        wait_start("start_frame3");
        iFFT_RDY = 1'b0;
        tick();
        iFFT_RDY = 1'b1;
        tick();
        check("refill_busy", 32'(oBUSY), 1);
        w0 = writes;
        fill(FRAME_N, 2, -1);
        check("frame4_writes", writes - w0, FRAME_N);
        wait_start("start_frame4");
        repeat (10) tick();
        check("two_starts", starts - s0, 2);
        check("exp_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
